ofs_axis_pkt_arb: RTL and testbench
===================================

Name: ofs_axis_pkt_arb

Overview:
- N-to-1 packet-level round-robin arbiter for AXI4-S streams.
- Shares one downstream AXI4-S sink (for example a host TX/PCIe egress stream) between N upstream sources.
- Grants are held for a whole packet, from first beat through the tlast beat, so packets never interleave.
- Sits between per-function/per-port AXI4-S sources and a single ofs_axis_if sink.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- TDATA_WIDTH, 512, data width per source; TKEEP width = TDATA_WIDTH/8.
- TUSER_WIDTH, 8, tuser width per source (must be >=1).
- SRC_W, $clog2(NUM_SRC), width of the source-index tag (derived localparam, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready
- s_tdata  in  NUM_SRC*TDATA_WIDTH  packed per-source data, source i at slice i
- s_tkeep  in  NUM_SRC*TDATA_WIDTH/8  packed keep
- s_tlast  in  NUM_SRC  per-source last
- s_tuser  in  NUM_SRC*TUSER_WIDTH  packed user
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tdata  out  TDATA_WIDTH  output data
- m_tkeep  out  TDATA_WIDTH/8  output keep
- m_tlast  out  1  output last
- m_tuser  out  TUSER_WIDTH  output user
- m_tid  out  SRC_W  index of the source that owns the current beat
- grant_busy  out  1  high while a packet is locked

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - State = IDLE, rr_ptr = 0, grant = 0.
  - m_tvalid = 0, s_tready = all 0, grant_busy = 0, m_tid = 0.
  - m_tdata/m_tkeep/m_tuser are don't-care while m_tvalid = 0; the RTL drives them to 0.
- FSM IDLE:
  - s_tready = 0 and m_tvalid = 0.
  - If any s_tvalid is high, choose the first requester at or after rr_ptr (cyclic order). Register it as grant and go to LOCKED next cycle.
  - Arbitration cost is exactly one bubble cycle per packet.
- FSM LOCKED:
  - m_* = s_*[grant] combinationally, m_tid = grant.
  - s_tready[grant] = m_tready; all other s_tready bits = 0.
  - grant_busy = 1.
- Packet end: on m_tvalid & m_tready & m_tlast, go to IDLE and set rr_ptr = (grant+1) mod NUM_SRC. rr_ptr wraps from NUM_SRC-1 to 0.
- Inside a packet, an s_tvalid[grant] drop does not release the grant. The block waits in LOCKED, passing m_tvalid = 0.
- A single-beat packet (tlast on the first beat) holds LOCKED for one transfer cycle, then returns to IDLE.
- Requests arriving while LOCKED are not considered until IDLE.
- A requester that deasserts tvalid while un-granted is legal and is simply not picked.
- If the lone requester equals rr_ptr's successor's predecessor (same source repeatedly), it wins every arbitration; no lockout.
- Async reset mid-packet abandons the packet: all outputs go to reset values immediately. Upstream and downstream are reset together.
- Downstream stability: m_tvalid never drops without m_tready inside LOCKED unless the source itself violates AXI-S. Sources obey AXI-S valid-hold, so the output obeys it too.
- Latency: 0 cycles data path (combinational mux); 1 cycle arbitration.

Optional Feature:
- Macro: OFS_AXIS_PKT_ARB_OUT_REG_EN.
- When defined:
  - A 2-entry skid register slice sits on all m_* outputs (including m_tid).
  - m_tvalid and m_tdata are registered, and m_tready is decoupled from s_tready timing.
  - Data latency +1 cycle; sustained throughput remains 1 beat/cycle.
  - Skid entries reset to empty (m_tvalid = 0).
  - The packet-end rr_ptr update uses the input-side handshake (beat accepted into the skid), not the m_ handshake.
- When not defined: combinational path as in Behaviour.

Decomposition:
- Package ofs_axis_pkt_arb_pkg holds:
  - the arb_state_e enum {IDLE, LOCKED};
  - a function rr_next(ptr, NUM_SRC).
- Sub-module ofs_axis_rr_pick is natural: a combinational round-robin picker with inputs req[NUM_SRC] and ptr[SRC_W], and outputs gnt_idx[SRC_W] and any_req. It is reused by other OFS arbiters.
- The skid register slice is an inline generate block under the macro.

Test Plan:
- Reset then single source: s_tvalid = 4'b0100, 3-beat packet, m_tready = 1 → one idle cycle, then 3 consecutive beats with m_tid = 2. rr_ptr = 3 after tlast.
- All 4 sources continuously valid, 2-beat packets → grant order 0,1,2,3,0, each packet contiguous with no interleaving. Exactly one bubble between packets.
- Backpressure: source 1 locked, m_tready toggles 1010 during a 4-beat packet → s_tready[1] mirrors m_tready, other s_tready stay 0. Data order is preserved.
- Source tvalid gap: source 3 drops tvalid for 5 cycles mid-packet while source 0 requests → grant stays 3 and m_tvalid = 0 during the gap. Source 0 is served only after source 3's tlast.
- Async reset mid-packet at beat 2 of 4 → m_tvalid and s_tready go to 0 in the same cycle, grant_busy = 0, and the next arbitration starts from rr_ptr = 0.
- With OFS_AXIS_PKT_ARB_OUT_REG_EN: repeat the round-robin test → identical beat sequence with +1 cycle latency. m_tready stalled for 3 cycles loses no beat.

Source files
------------

// File: rtl/ofs_axis_pkt_arb_pkg.sv
// ofs_axis_pkt_arb_pkg: shared types and helpers for the packet-level AXI4-S
// round-robin arbiter (ofs_axis_pkt_arb) and its round-robin picker.
package ofs_axis_pkt_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Cyclic successor of a source index: NUM_SRC-1 wraps to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_src);
    return (ptr + 32'd1 >= num_src) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ofs_axis_rr_pick.sv
// ofs_axis_rr_pick: combinational round-robin picker. Returns the first
// asserted request at or after ptr in cyclic order; any_req flags that at
// least one request is present (gnt_idx is 0 otherwise).
module ofs_axis_rr_pick #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               any_req
);

  logic [SRC_W-1:0] cand;
  logic             found;

  // Scan sources starting at ptr and keep the first requester encountered.
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((32'(ptr) + i) % NUM_SRC);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ofs_axis_pkt_arb.sv
// ofs_axis_pkt_arb: N-to-1 packet-level round-robin arbiter for AXI4-S.
// A grant is held from the first beat through the tlast beat, so packets
// never interleave; each arbitration costs one idle cycle.
// Optional macro OFS_AXIS_PKT_ARB_OUT_REG_EN adds a 2-entry skid register
// slice on all m_* outputs (+1 cycle latency, full throughput).
module ofs_axis_pkt_arb
  import ofs_axis_pkt_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC     = 4,
  parameter  int unsigned TDATA_WIDTH = 512,
  parameter  int unsigned TUSER_WIDTH = 8,
  localparam int unsigned SRC_W       = $clog2(NUM_SRC),
  localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             s_tvalid,
  output logic [NUM_SRC-1:0]             s_tready,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC*TKEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]             s_tlast,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0] s_tuser,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [TDATA_WIDTH-1:0]         m_tdata,
  output logic [TKEEP_WIDTH-1:0]         m_tkeep,
  output logic                           m_tlast,
  output logic [TUSER_WIDTH-1:0]         m_tuser,
  output logic [SRC_W-1:0]               m_tid,
  output logic                           grant_busy
);

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;
  logic             pkt_end;

  // Arbiter-side stream, before the optional output register slice.
  logic                   a_tvalid;
  logic                   a_tready;
  logic [TDATA_WIDTH-1:0] a_tdata;
  logic [TKEEP_WIDTH-1:0] a_tkeep;
  logic                   a_tlast;
  logic [TUSER_WIDTH-1:0] a_tuser;
  logic [SRC_W-1:0]       a_tid;

  ofs_axis_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req     (s_tvalid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  // Packet ends on the accepted tlast beat at the arbiter side.
  assign pkt_end = a_tvalid & a_tready & a_tlast;

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state: lock the picked source in IDLE, release after its tlast.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCKED;
          grant_d = pick_idx;
        end
      end
      LOCKED: begin
        if (pkt_end) begin
          state_d  = IDLE;
          rr_ptr_d = SRC_W'(rr_next(32'(grant_q), NUM_SRC));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: route the granted source through while LOCKED, quiet in IDLE.
  always_comb begin
    a_tvalid   = 1'b0;
    a_tdata    = '0;
    a_tkeep    = '0;
    a_tlast    = 1'b0;
    a_tuser    = '0;
    a_tid      = '0;
    s_tready   = '0;
    grant_busy = 1'b0;
    if (state_q == LOCKED) begin
      grant_busy = 1'b1;
      a_tid      = grant_q;
      a_tvalid   = s_tvalid[grant_q];
      a_tlast    = s_tlast[grant_q];
      a_tdata    = TDATA_WIDTH'(s_tdata >> (32'(grant_q) * TDATA_WIDTH));
      a_tkeep    = TKEEP_WIDTH'(s_tkeep >> (32'(grant_q) * TKEEP_WIDTH));
      a_tuser    = TUSER_WIDTH'(s_tuser >> (32'(grant_q) * TUSER_WIDTH));
      s_tready   = NUM_SRC'(a_tready) << grant_q;
    end
  end

`ifdef OFS_AXIS_PKT_ARB_OUT_REG_EN
  localparam int unsigned PW = SRC_W + TUSER_WIDTH + 1 + TKEEP_WIDTH + TDATA_WIDTH;

  logic [PW-1:0] a_pay;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_vld_q;
  logic          skid_vld_q;

  assign a_pay    = {a_tid, a_tuser, a_tlast, a_tkeep, a_tdata};
  // Upstream ready depends only on skid occupancy, not on m_tready.
  assign a_tready = ~skid_vld_q;

  // Skid slice: output stage advances when free or consumed; a beat arriving
  // while the output stage is stalled is parked in the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (m_tready || !main_vld_q) begin
      if (skid_vld_q) begin
        main_q     <= skid_q;
        main_vld_q <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        main_q     <= a_pay;
        main_vld_q <= a_tvalid;
      end
    end else if (a_tvalid && !skid_vld_q) begin
      skid_q     <= a_pay;
      skid_vld_q <= 1'b1;
    end
  end

  assign m_tvalid = main_vld_q;
  assign {m_tid, m_tuser, m_tlast, m_tkeep, m_tdata} = main_q;
`else
  assign a_tready = m_tready;
  assign m_tvalid = a_tvalid;
  assign m_tdata  = a_tdata;
  assign m_tkeep  = a_tkeep;
  assign m_tlast  = a_tlast;
  assign m_tuser  = a_tuser;
  assign m_tid    = a_tid;
`endif

endmodule

// File: tb/tb_ofs_axis_pkt_arb.sv
// tb_ofs_axis_pkt_arb: scoreboard bench for ofs_axis_pkt_arb. Per-source
// packet queues feed an AXI-S driver; a queue-level round-robin model
// predicts the output beat order, and a monitor checks every output beat.
module tb_ofs_axis_pkt_arb;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = 8;
  localparam int unsigned SW = 2;

`ifdef OFS_AXIS_PKT_ARB_OUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct packed {
    logic [SW-1:0] tid;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic                  clk;
  logic                  rst;
  logic [NS-1:0]         s_tvalid;
  logic [NS-1:0]         s_tready;
  logic [NS-1:0]         s_tlast;
  logic [NS-1:0][DW-1:0] src_data;
  logic [NS-1:0][KW-1:0] src_keep;
  logic [NS-1:0][UW-1:0] src_user;
  logic [NS*DW-1:0]      s_tdata;
  logic [NS*KW-1:0]      s_tkeep;
  logic [NS*UW-1:0]      s_tuser;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [DW-1:0]         m_tdata;
  logic [KW-1:0]         m_tkeep;
  logic                  m_tlast;
  logic [UW-1:0]         m_tuser;
  logic [SW-1:0]         m_tid;
  logic                  grant_busy;

  assign s_tdata = src_data;
  assign s_tkeep = src_keep;
  assign s_tuser = src_user;

  ofs_axis_pkt_arb #(
    .NUM_SRC     (NS),
    .TDATA_WIDTH (DW),
    .TUSER_WIDTH (UW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .m_tid      (m_tid),
    .grant_busy (grant_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  beat_t       src_q[NS][$];
  beat_t       exp_q[$];
  int          model_ptr = 0;
  int unsigned cyc = 0;
  int unsigned hs_count = 0;
  int unsigned gap_force[NS];
  bit          in_pkt[NS];
  bit          gap_active[NS];
  bit          gap_rand_en = 1'b0;
  bit          strict_gap = 1'b0;
  bit          prev_hs_valid = 1'b0;
  bit          prev_last = 1'b0;
  int unsigned prev_cyc = 0;
  int          rdy_mode = 0;
  int          phase_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_pkt(input int src, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.tid  = SW'(src);
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.last = (j == len - 1);
      b.user = UW'($urandom);
      src_q[src].push_back(b);
    end
  endtask

  // Reference: every source holding packets requests; serve whole packets
  // in cyclic order starting at the pointer, pointer moves past the winner.
  task automatic run_model();
    beat_t pend[NS][$];
    beat_t b;
    int    pick;
    int    s;
    for (int i = 0; i < NS; i++) pend[i] = src_q[i];
    forever begin
      pick = -1;
      for (int k = 0; k < NS; k++) begin
        s = (model_ptr + k) % NS;
        if (pick < 0 && pend[s].size() > 0) pick = s;
      end
      if (pick < 0) break;
      do begin
        b = pend[pick].pop_front();
        exp_q.push_back(b);
      end while (!b.last);
      model_ptr = (pick + 1) % NS;
    end
  endtask

  task automatic drive_ready();
    case (rdy_mode)
      1:       m_tready = ($urandom_range(3) != 0);
      2:       m_tready = ~m_tready;
      3:       m_tready = !(phase_cyc >= 3 && phase_cyc < 6);
      default: m_tready = 1'b1;
    endcase
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    phase_cyc = 0;
    forever begin
      done = (exp_q.size() == 0);
      for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) done = 1'b0;
      if (done || n >= budget) break;
      @(posedge clk); #2;
      n++;
      phase_cyc++;
      drive_ready();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding after %0d cycles, expected 0", name, exp_q.size(), budget);
    end
    rdy_mode = 0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Source driver: AXI-S compliant, holds valid/data until accepted; gaps
  // only start between beats of a packet that is already underway.
  initial begin
    logic [NS-1:0] acc;
    s_tvalid = '0;
    s_tlast  = '0;
    src_data = '0;
    src_keep = '0;
    src_user = '0;
    for (int i = 0; i < NS; i++) begin
      gap_force[i]  = 0;
      in_pkt[i]     = 1'b0;
      gap_active[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) begin
        if (rst) begin
          s_tvalid[SW'(i)] = 1'b0;
          in_pkt[i]        = 1'b0;
          gap_active[i]    = 1'b0;
          continue;
        end
        if (acc[SW'(i)] && src_q[i].size() > 0) begin
          in_pkt[i] = !src_q[i][0].last;
          void'(src_q[i].pop_front());
        end
        if (s_tvalid[SW'(i)] && !acc[SW'(i)]) continue;
        if (src_q[i].size() == 0) begin
          s_tvalid[SW'(i)] = 1'b0;
        end else if (in_pkt[i] && gap_force[i] > 0) begin
          gap_force[i]--;
          gap_active[i]    = 1'b1;
          s_tvalid[SW'(i)] = 1'b0;
        end else if (in_pkt[i] && gap_rand_en && $urandom_range(2) == 0) begin
          s_tvalid[SW'(i)] = 1'b0;
        end else begin
          gap_active[i]    = 1'b0;
          s_tvalid[SW'(i)] = 1'b1;
          src_data[SW'(i)] = src_q[i][0].data;
          src_keep[SW'(i)] = src_q[i][0].keep;
          s_tlast[SW'(i)]  = src_q[i][0].last;
          src_user[SW'(i)] = src_q[i][0].user;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    beat_t         e;
    logic [NS-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) continue;
`ifndef OFS_AXIS_PKT_ARB_OUT_REG_EN
      exp_rdy = '0;
      if (grant_busy && exp_q.size() > 0) exp_rdy = NS'(m_tready) << exp_q[0].tid;
      chk("s_tready_route", 64'(s_tready), 64'(exp_rdy));
`endif
      if (m_tvalid && m_tready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got tid %0d data %0h, expected no beat", m_tid, m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("m_tid", 64'(m_tid), 64'(e.tid));
          chk("m_tdata", 64'(m_tdata), 64'(e.data));
          chk("m_tkeep", 64'(m_tkeep), 64'(e.keep));
          chk("m_tlast", 64'(m_tlast), 64'(e.last));
          chk("m_tuser", 64'(m_tuser), 64'(e.user));
        end
        if (strict_gap && prev_hs_valid)
          chk("beat_spacing", 64'(cyc - prev_cyc), prev_last ? 64'd2 : 64'd1);
        prev_hs_valid = 1'b1;
        prev_cyc      = cyc;
        prev_last     = m_tlast;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int unsigned base;
    rst      = 1'b1;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_grant_busy", 64'(grant_busy), 64'd0);
    chk("rst_m_tid", 64'(m_tid), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Single source 2, 3-beat packet: idle bubble then 3 back-to-back beats.
    @(posedge clk); #2;
    load_pkt(2, 3);
    run_model();
    @(negedge clk);
    repeat (LAT) begin
      @(negedge clk);
      chk("single_bubble_tvalid", 64'(m_tvalid), 64'd0);
    end
    @(negedge clk);
    chk("single_busy", 64'(grant_busy), 64'd1);
    chk("single_beat1_tvalid", 64'(m_tvalid), 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("single_contig_tvalid", 64'(m_tvalid), 64'd1);
    end
    @(negedge clk);
    chk("single_after_tvalid", 64'(m_tvalid), 64'd0);
    chk("single_after_busy", 64'(grant_busy), 64'd0);
    @(posedge clk); #2;
    wait_drain("single", 20);

    // All sources valid, 2-beat packets: rotation continues from source 3.
    prev_hs_valid = 1'b0;
    strict_gap    = 1'b1;
    for (int s = 0; s < NS; s++) begin
      load_pkt(s, 2);
      load_pkt(s, 2);
    end
    run_model();
    wait_drain("round_robin", 100);
    strict_gap = 1'b0;

    // Backpressure 1010 on source 1.
    rdy_mode = 2;
    m_tready = 1'b1;
    load_pkt(1, 4);
    run_model();
    wait_drain("backpressure", 40);

    // Source 3 stalls 5 cycles mid-packet while source 0 waits.
    gap_force[3] = 5;
    load_pkt(3, 4);
    load_pkt(0, 2);
    run_model();
    n = 0;
    while (!gap_active[3] && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("gap_reached", 64'(gap_active[3]), 64'd1);
    chk("gap_busy", 64'(grant_busy), 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("gap_tvalid", 64'(m_tvalid), 64'd0);
      chk("gap_busy_hold", 64'(grant_busy), 64'd1);
    end
    @(posedge clk); #2;
    wait_drain("gap", 60);

    // Randomized rounds: mixed lengths incl. single-beat, gaps, backpressure.
    gap_rand_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < NS; s++) begin
        repeat ($urandom_range(2)) load_pkt(s, $urandom_range(1, 4));
      end
      run_model();
      rdy_mode = r % 4;
      wait_drain("random", 400);
    end
    gap_rand_en = 1'b0;

    // Async reset at beat 2 of 4 from source 2 (pointer left at 2 first).
    load_pkt(1, 1);
    run_model();
    wait_drain("pre_reset", 20);
    load_pkt(2, 4);
    run_model();
    base = hs_count;
    n = 0;
    while (hs_count < base + 2 && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reset_reached_beat2", 64'(hs_count - base), 64'd2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("arst_s_tready", 64'(s_tready), 64'd0);
    chk("arst_grant_busy", 64'(grant_busy), 64'd0);
    chk("arst_m_tid", 64'(m_tid), 64'd0);
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      gap_force[i] = 0;
    end
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    load_pkt(1, 2);
    load_pkt(3, 2);
    run_model();
    wait_drain("post_reset", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
